// File: rtl/fifo_read_drainer_if.sv
// Interface bundling the FIFO read port and the downstream valid/ready stream
// of the FIFO read drainer.
//   master : drainer side  (drives read_enable, out_data, out_valid,
//                           burst_active, rd_count)
//   slave  : environment side (drives rempty, half_full, data_read, out_ready)
interface fifo_read_drainer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rempty;
  logic                  half_full;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] data_read;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  burst_active;
  logic [15:0]           rd_count;

  modport master (
    input  rempty, half_full, data_read, out_ready,
    output read_enable, out_data, out_valid, burst_active, rd_count
  );

  modport slave (
    output rempty, half_full, data_read, out_ready,
    input  read_enable, out_data, out_valid, burst_active, rd_count
  );
endinterface

// File: rtl/fifo_read_drainer.sv
// Read-side controller for an async FIFO (rclk domain).
// Pops the FIFO with read_enable, absorbs its 1-cycle read latency and
// re-presents the words on a valid/ready stream through a 2-entry buffer.
// Reads in bursts of up to BURST_LEN words while the FIFO reports half_full,
// and drains low-level data that has sat in the FIFO for TIMEOUT idle cycles.
// Ports:
//   rclk          read-domain clock, all logic on posedge
//   rrst          synchronous active-high reset
//   bus.rempty    FIFO empty flag          bus.half_full   FIFO >= half depth
//   bus.read_enable  FIFO pop (data next cycle)   bus.data_read  FIFO data
//   bus.out_data/out_valid/out_ready  output stream (head of buffer)
//   bus.burst_active  high in BURST or DRAIN      bus.rd_count  reads issued
module fifo_read_drainer #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                rclk,
  input  logic                rrst,
  fifo_read_drainer_if.master bus
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
  logic                  pending_q;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [15:0]           rd_count_q;
  logic                  burst_active_q;

  logic                  pop_s;
  logic                  rd_en_s;
  logic [2:0]            occ_s;
  logic [BW-1:0]         burst_nxt_s;

  // A word leaves the buffer whenever the head is valid and accepted.
  assign pop_s = (buf_cnt_q != 2'd0) & bus.out_ready;
  // Occupancy after this edge: buffered words plus the word still in flight
  // from the FIFO, minus the one leaving now. A new read is safe while < 2.
  assign occ_s = {1'b0, buf_cnt_q} + {2'b00, pending_q} - {2'b00, pop_s};
  assign burst_nxt_s = burst_cnt_q + {{(BW-1){1'b0}}, rd_en_s};

  // Read issue: only when reading states, FIFO non-empty and buffer room.
  always_comb begin
    rd_en_s = 1'b0;
    case (state_q)
      S_BURST: rd_en_s = !bus.rempty && (occ_s < 3'd2) && (burst_cnt_q < BURST_MAX);
      S_DRAIN: rd_en_s = !bus.rempty && (occ_s < 3'd2);
      default: rd_en_s = 1'b0;
    endcase
  end

  // Next-state logic for the IDLE/BURST/DRAIN controller and its counters.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = {TW{1'b0}};
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.half_full) begin
          state_d     = S_BURST;
          burst_cnt_d = {BW{1'b0}};
        end else if (!bus.rempty) begin
          // Data is sitting below the half level: count towards a drain.
          if (to_cnt_q == TO_LAST) begin
            state_d = S_DRAIN;
          end else begin
            to_cnt_d = to_cnt_q + {{(TW-1){1'b0}}, 1'b1};
          end
        end else begin
          to_cnt_d = {TW{1'b0}};
        end
      end
      S_BURST: begin
        burst_cnt_d = burst_nxt_s;
        if ((burst_nxt_s == BURST_MAX) || (bus.rempty && !rd_en_s)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BURST;
        end
      end
      S_DRAIN: begin
        if (bus.rempty && !rd_en_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two-entry output buffer: buf0 is the head, the returning FIFO word
  // is appended at the tail; push and pop together keep the count.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    case ({pending_q, pop_s})
      2'b10: begin
        if (buf_cnt_q == 2'd0) begin
          buf0_d = bus.data_read;
        end else begin
          buf1_d = bus.data_read;
        end
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = bus.data_read;
        end else begin
          buf0_d = buf1_q;
          buf1_d = bus.data_read;
        end
      end
      default: begin
        buf_cnt_d = buf_cnt_q;
      end
    endcase
  end

  // State, counters, capture pipeline and output registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q        <= S_IDLE;
      to_cnt_q       <= {TW{1'b0}};
      burst_cnt_q    <= {BW{1'b0}};
      pending_q      <= 1'b0;
      buf_cnt_q      <= 2'd0;
      buf0_q         <= {DATA_WIDTH{1'b0}};
      buf1_q         <= {DATA_WIDTH{1'b0}};
      rd_count_q     <= 16'h0000;
      burst_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      to_cnt_q       <= to_cnt_d;
      burst_cnt_q    <= burst_cnt_d;
      pending_q      <= rd_en_s;
      buf_cnt_q      <= buf_cnt_d;
      buf0_q         <= buf0_d;
      buf1_q         <= buf1_d;
      rd_count_q     <= rd_count_q + {15'h0000, rd_en_s};
      burst_active_q <= (state_d != S_IDLE);
    end
  end

  assign bus.read_enable  = rd_en_s;
  assign bus.out_data     = buf0_q;
  assign bus.out_valid    = (buf_cnt_q != 2'd0);
  assign bus.burst_active = burst_active_q;
  assign bus.rd_count     = rd_count_q;
endmodule

// File: tb/tb_fifo_read_drainer.sv
// Bench for fifo_read_drainer: a FIFO model feeds the read port and a
// scoreboard queue holds popped words until the stream delivers them.
module tb_fifo_read_drainer;
  localparam int DW = 8;

  logic rclk = 1'b0;
  logic rrst = 1'b1;
  always #5 rclk = ~rclk;

  fifo_read_drainer_if #(.DATA_WIDTH(DW)) bus ();

  fifo_read_drainer #(.DATA_WIDTH(DW), .BURST_LEN(4), .TIMEOUT(16)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  int          total = 0;
  int          bad = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [15:0] n_reads = 16'h0000;
  int          delivered = 0;
  bit          hf_force = 1'b0;
  bit          hf_block = 1'b0;

  // FIFO model + scoreboard: sample at negedge+1, update FIFO outputs at posedge+1.
  initial begin : fifo_model
    logic [DW-1:0] staged;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] e;
    bit            staged_v;
    bit            prev_stall;
    staged = '0; prev_data = '0; staged_v = 1'b0; prev_stall = 1'b0;
    bus.rempty = 1'b1; bus.half_full = 1'b0; bus.data_read = '0;
    forever begin
      @(negedge rclk); #1;
      total++;
      if (bus.read_enable === 1'b1 && bus.rempty === 1'b1) begin
        bad++;
        $display("FAIL read_while_empty: read_enable=%0b rempty=%0b, required read_enable=0", bus.read_enable, bus.rempty);
      end
      if (prev_stall) begin
        total++;
        if (bus.out_data !== prev_data) begin
          bad++;
          $display("FAIL stall_stability: out_data=%0h required %0h", bus.out_data, prev_data);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: out_data=%0h with no word outstanding", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            bad++;
            $display("FAIL stream_order: out_data=%0h required %0h", bus.out_data, e);
          end
          delivered++;
        end
      end
      prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      prev_data  = bus.out_data;
      if (bus.read_enable === 1'b1 && fifo_q.size() > 0) begin
        staged = fifo_q.pop_front();
        staged_v = 1'b1;
        exp_q.push_back(staged);
        n_reads++;
      end
      if (rrst) begin
        exp_q.delete();
        n_reads = 16'h0000;
        delivered = 0;
        prev_stall = 1'b0;
      end
      @(posedge rclk); #1;
      if (staged_v) bus.data_read = staged;
      else          bus.data_read = DW'($urandom);
      staged_v = 1'b0;
      bus.rempty    = (fifo_q.size() == 0);
      bus.half_full = ((fifo_q.size() >= 8) || hf_force) && !hf_block;
    end
  end

  task automatic tick();
    @(negedge rclk); #2;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      tick();
      if (fifo_q.size() == 0 && exp_q.size() == 0 && bus.out_valid === 1'b0 &&
          bus.burst_active === 1'b0 && bus.read_enable === 1'b0) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: idle not reached in %0d cycles, fifo=%0d outstanding=%0d", tag, max_cyc, fifo_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    bit seen = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        @(negedge rclk); bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(8'hB0 + i));
        #2;
        for (int i = 0; i < 10 && !seen; i++) begin
          tick();
          if (bus.read_enable === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL rst_burst_start: no read_enable within 10 cycles, required one"); end
        @(negedge rclk); rrst = 1'b1; #2;
      end
      tick();
      total += 5;
      if (bus.read_enable !== 1'b0) begin bad++; $display("FAIL rst_read_enable[%0d]: %0b required 0", pass, bus.read_enable); end
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid[%0d]: %0b required 0", pass, bus.out_valid); end
      if (bus.out_data !== '0) begin bad++; $display("FAIL rst_out_data[%0d]: %0h required 0", pass, bus.out_data); end
      if (bus.burst_active !== 1'b0) begin bad++; $display("FAIL rst_burst_active[%0d]: %0b required 0", pass, bus.burst_active); end
      if (bus.rd_count !== 16'h0000) begin bad++; $display("FAIL rst_rd_count[%0d]: %0h required 0", pass, bus.rd_count); end
      @(negedge rclk); rrst = 1'b0; #2;
    end
    // Two words were popped before the reset took hold; the other six follow.
    wait_idle(200, "rst_drain");
    total += 2;
    if (bus.rd_count !== 16'd6) begin bad++; $display("FAIL rst_rd_count_after: %0d required 6", bus.rd_count); end
    if (delivered != 6) begin bad++; $display("FAIL rst_delivered: %0d required 6", delivered); end
  endtask

  task automatic test_burst();
    logic [15:0]   base;
    logic          re[6], ov[6], ba[6];
    logic [DW-1:0] od[6];
    logic [15:0]   rc4;
    bit            seen = 1'b0;
    base = n_reads;
    @(negedge rclk); bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(8'hA0 + i));
    #2;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (bus.read_enable === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL burst_start: no read_enable within 10 cycles, required one"); end
    rc4 = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      re[i] = bus.read_enable; ov[i] = bus.out_valid; od[i] = bus.out_data; ba[i] = bus.burst_active;
      if (i == 4) rc4 = bus.rd_count;
    end
    for (int i = 0; i < 6; i++) begin
      total += 2;
      if (re[i] !== (i < 4)) begin bad++; $display("FAIL burst_read_enable[%0d]: %0b required %0b", i, re[i], (i < 4)); end
      if (ov[i] !== (i >= 2)) begin bad++; $display("FAIL burst_out_valid[%0d]: %0b required %0b", i, ov[i], (i >= 2)); end
      if (i >= 2) begin
        total++;
        if (od[i] !== DW'(8'hA0 + i - 2)) begin bad++; $display("FAIL burst_out_data[%0d]: %0h required %0h", i, od[i], DW'(8'hA0 + i - 2)); end
      end
    end
    total += 3;
    if (ba[0] !== 1'b1) begin bad++; $display("FAIL burst_active_in: %0b required 1", ba[0]); end
    if (ba[4] !== 1'b0) begin bad++; $display("FAIL burst_active_out: %0b required 0", ba[4]); end
    if (rc4 !== base + 16'd4) begin bad++; $display("FAIL burst_rd_count: %0d required %0d", rc4, base + 16'd4); end
    wait_idle(200, "burst_drain");
    total += 2;
    if (bus.rd_count !== base + 16'd8) begin bad++; $display("FAIL burst_rd_count_end: %0d required %0d", bus.rd_count, base + 16'd8); end
    if (delivered != int'(n_reads)) begin bad++; $display("FAIL burst_delivered: %0d required %0d", delivered, n_reads); end
  endtask

  task automatic test_timeout();
    int            first_hi = 0;
    bit            got = 1'b0;
    logic [DW-1:0] word = '0;
    logic          ba17 = 1'b0, ba19 = 1'b1;
    @(negedge rclk); bus.out_ready = 1'b1; fifo_q.push_back(DW'(8'h5A)); #2;
    for (int j = 1; j <= 22; j++) begin
      tick();
      if (bus.read_enable === 1'b1 && first_hi == 0) first_hi = j;
      if (bus.out_valid === 1'b1 && !got) begin got = 1'b1; word = bus.out_data; end
      if (j == 17) ba17 = bus.burst_active;
      if (j == 19) ba19 = bus.burst_active;
    end
    total += 4;
    if (first_hi != 17) begin bad++; $display("FAIL timeout_first_read: cycle %0d required 17", first_hi); end
    if (!got || word !== DW'(8'h5A)) begin bad++; $display("FAIL timeout_word: got=%0b data=%0h required 5a", got, word); end
    if (ba17 !== 1'b1) begin bad++; $display("FAIL timeout_drain_active: %0b required 1", ba17); end
    if (ba19 !== 1'b0) begin bad++; $display("FAIL timeout_back_idle: %0b required 0", ba19); end
    wait_idle(50, "timeout_idle");
  endtask

  task automatic test_backpressure();
    logic [15:0] base;
    int          n1 = 0, n2 = 0;
    base = n_reads;
    @(negedge rclk); bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(8'hC0 + i));
    #2;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (bus.read_enable === 1'b1) n1++;
      if (j >= 9) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(8'hC0)) begin
          bad++; $display("FAIL bp_head[%0d]: valid=%0b data=%0h required valid=1 data=c0", j, bus.out_valid, bus.out_data);
        end
      end
    end
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin @(negedge rclk); bus.out_ready = 1'b1; #2; end
      else tick();
      if (bus.read_enable === 1'b1) n2++;
    end
    total += 2;
    if (n1 != 2) begin bad++; $display("FAIL bp_stalled_reads: %0d required 2", n1); end
    if (n2 != 2) begin bad++; $display("FAIL bp_released_reads: %0d required 2", n2); end
    wait_idle(200, "bp_drain");
    total += 2;
    if (bus.rd_count !== base + 16'd8) begin bad++; $display("FAIL bp_rd_count: %0d required %0d", bus.rd_count, base + 16'd8); end
    if (delivered != int'(n_reads)) begin bad++; $display("FAIL bp_delivered: %0d required %0d", delivered, n_reads); end
  endtask

  task automatic test_empty_mid_burst();
    int   n = 0;
    int   d0;
    logic re4 = 1'b1, ba3 = 1'b0, ba5 = 1'b1;
    d0 = delivered;
    @(negedge rclk); bus.out_ready = 1'b1; hf_force = 1'b1;
    fifo_q.push_back(DW'(8'hD0)); fifo_q.push_back(DW'(8'hD1));
    #2;
    for (int j = 1; j <= 12; j++) begin
      if (j == 1) begin @(negedge rclk); hf_force = 1'b0; #2; end
      else tick();
      if (bus.read_enable === 1'b1) n++;
      if (j == 3) ba3 = bus.burst_active;
      if (j == 4) re4 = bus.read_enable;
      if (j == 5) ba5 = bus.burst_active;
    end
    total += 5;
    if (n != 2) begin bad++; $display("FAIL emb_reads: %0d required 2", n); end
    if (re4 !== 1'b0) begin bad++; $display("FAIL emb_read_after_empty: %0b required 0", re4); end
    if (ba3 !== 1'b1) begin bad++; $display("FAIL emb_in_burst: %0b required 1", ba3); end
    if (ba5 !== 1'b0) begin bad++; $display("FAIL emb_back_idle: %0b required 0", ba5); end
    if (delivered - d0 != 2) begin bad++; $display("FAIL emb_delivered: %0d required 2", delivered - d0); end
    wait_idle(50, "emb_idle");
  endtask

  task automatic test_rd_count_wrap();
    @(negedge rclk); rrst = 1'b1; hf_block = 1'b1; bus.out_ready = 1'b1; #2;
    tick();
    @(negedge rclk); rrst = 1'b0; #2;
    for (int i = 0; i < 65535; i++) fifo_q.push_back(DW'(i));
    wait_idle(70000, "wrap_preload");
    total++;
    if (bus.rd_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload_count: %0h required ffff", bus.rd_count); end
    @(negedge rclk); fifo_q.push_back(DW'(8'hEE)); #2;
    wait_idle(100, "wrap_last");
    total++;
    if (bus.rd_count !== 16'h0000) begin bad++; $display("FAIL wrap_count: %0h required 0", bus.rd_count); end
    hf_block = 1'b0;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_burst();
    test_timeout();
    test_backpressure();
    test_empty_mid_burst();
    test_rd_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
